// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package instr_mem_loader_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } ld_state_e;

    // Even parity bit: the stored bit makes the XOR over word plus parity zero.
    function automatic logic even_parity(input logic [INSTR_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; pulses word_valid_o with the completed word
// on the same cycle the 4th byte is presented.
module imem_byte_packer
    import instr_mem_loader_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_i,
    output logic               word_valid_o,
    output logic [INSTR_W-1:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] asm_q, asm_d;

    always_comb begin
        cnt_d = cnt_q;
        asm_d = asm_q;
        if (byte_valid_i) begin
            case (cnt_q)
                2'd0:    asm_d[7:0]   = byte_i;
                2'd1:    asm_d[15:8]  = byte_i;
                2'd2:    asm_d[23:16] = byte_i;
                default: asm_d        = asm_q;
            endcase
            cnt_d = cnt_q + 2'd1;
        end
        // A restart or exit drops any partial word.
        if (clear_i) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= 2'd0;
            asm_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end

    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, asm_q};

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-stream program loader and a 1-cycle fetch port.
// Build option: define IMEM_PARITY_EN to store per-word parity and add parity_err_o.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int                 ADDR_W   = 8,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_DEFAULT
)
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [31:0]        pc_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    input  logic               ld_start_i,
    input  logic               ld_end_i,
    input  logic               ld_valid_i,
    input  logic [7:0]         ld_byte_i,
    output logic               ld_ready_o,
    output logic               load_active_o,
    output logic [ADDR_W:0]    ld_words_o
`ifdef IMEM_PARITY_EN
    ,
    output logic               parity_err_o
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [INSTR_W-1:0] mem [DEPTH];

    ld_state_e          state_q, state_d;
    logic [ADDR_W:0]    ld_words_q, ld_words_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    logic               byte_accept;
    logic               word_we;
    logic [INSTR_W-1:0] word_data;
    logic [ADDR_W-1:0]  rd_idx;
    logic [ADDR_W-1:0]  wr_idx;
    logic               pc_out_of_range;

    // The counter's MSB is set exactly when all DEPTH words have been written.
    assign ld_ready_o      = (state_q == ST_LOAD) && !ld_words_q[ADDR_W];
    assign byte_accept     = ld_valid_i && ld_ready_o;
    assign rd_idx          = pc_i[ADDR_W+1:2];
    assign wr_idx          = ld_words_q[ADDR_W-1:0];
    assign pc_out_of_range = |pc_i[31:ADDR_W+2];

    imem_byte_packer u_packer (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (ld_start_i || ld_end_i),
        .byte_valid_i (byte_accept),
        .byte_i       (ld_byte_i),
        .word_valid_o (word_we),
        .word_o       (word_data)
    );

    always_comb begin
        state_d    = state_q;
        ld_words_d = ld_words_q;
        if (word_we) begin
            ld_words_d = ld_words_q + 1'b1;
        end
        if (ld_start_i) begin
            state_d    = ST_LOAD;
            ld_words_d = '0;
        end else if (ld_end_i) begin
            state_d    = ST_RUN;
        end
    end

    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        if (state_q == ST_LOAD || flush_i) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            instr_d = pc_out_of_range ? NOP_WORD : mem[rd_idx];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_RUN;
            ld_words_q <= '0;
            instr_q    <= NOP_WORD;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_words_q <= ld_words_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    // Contents survive reset so a reset does not wipe a loaded program.
    always_ff @(posedge clk_i) begin
        if (word_we) begin
            mem[wr_idx] <= word_data;
        end
    end

    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign load_active_o = (state_q == ST_LOAD);
    assign ld_words_o    = ld_words_q;

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic perr_q, perr_d;

    always_ff @(posedge clk_i) begin
        if (word_we) begin
            par_mem[wr_idx] <= even_parity(word_data);
        end
    end

    always_comb begin
        perr_d = perr_q;
        if (state_q == ST_LOAD || flush_i) begin
            perr_d = 1'b0;
        end else if (!stall_i) begin
            perr_d = !pc_out_of_range && (even_parity(mem[rd_idx]) != par_mem[rd_idx]);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err_o = perr_q;
`endif

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, word-address bits; depth DEPTH = 2**ADDR_W words of 32 bits.
REQ-002 Parameter NOP_WORD, default 32'h00000000, word returned for flushed, out-of-range or load-time fetches.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc  input  32  byte fetch address; word index pc[ADDR_W+1:2].
REQ-006 stall  input  1  hold fetch output register.
REQ-007 flush  input  1  replace next fetch output with NOP_WORD.
REQ-008 instr  output  32  registered instruction.
REQ-009 instr_valid  output  1  instr holds a real fetched word.
REQ-010 ld_start  input  1  enter load mode, clear write pointer.
REQ-011 ld_end  input  1  leave load mode.
REQ-012 ld_valid / ld_byte  input  1 / 8  program byte strobe and data.
REQ-013 ld_ready  output  1  byte accepted when ld_valid & ld_ready.
REQ-014 load_active  output  1  high in LOAD state.
REQ-015 ld_words  output  ADDR_W+1  words written since last ld_start.

Function
REQ-016 States RUN, LOAD; reset state RUN; memory array is not reset.
REQ-017 RUN->LOAD on ld_start; LOAD->RUN on ld_end; ld_start wins if both high; ld_start in LOAD restarts (pointer and byte count to 0).
REQ-018 LOAD: accepted bytes assemble little-endian (first byte -> bits 7:0); 4th byte writes word at mem[ld_words], ld_words increments same edge.
REQ-019 ld_ready = LOAD and ld_words < DEPTH; full memory refuses further bytes, no wrap.
REQ-020 Partial word (1-3 bytes) pending at ld_end or ld_start is discarded.
REQ-021 RUN fetch latency 1 cycle: instr <= mem[pc index], instr_valid <= 1, when stall=0.
REQ-022 pc bits [31:ADDR_W+2] nonzero: instr <= NOP_WORD, instr_valid <= 1 (out-of-range reads as nop).
REQ-023 flush has priority over stall: instr <= NOP_WORD, instr_valid <= 0.
REQ-024 stall=1, flush=0: instr and instr_valid hold.
REQ-025 LOAD: instr <= NOP_WORD, instr_valid <= 0 every cycle regardless of stall.
REQ-026 First RUN cycle after ld_end fetches newly written contents (no read-during-write hazard; reads disabled in LOAD).

Reset
REQ-027 Reset asserted any time (including mid-word in LOAD): state RUN, instr NOP_WORD, instr_valid 0, ld_words 0, byte count 0, load_active 0, ld_ready 0; memory contents retained.

Configuration
REQ-028 Macro IMEM_PARITY_EN: defined -> each word stores an even-parity bit on write, output parity_err (1 bit) registered with instr, high when fetched word parity mismatches, 0 on nop/flush/reset.
REQ-029 Undefined -> no parity storage, no parity_err port.

Structure
REQ-030 Shared package holds state enum (RUN, LOAD), default NOP_WORD, instruction width constant 32.
REQ-031 One sub-module natural: imem_byte_packer (byte counter plus 32-bit assembler, emits word strobe).

Verification
REQ-032 Reset, ld_start, bytes 00 00 04 8c 00 00 10 20, ld_end, pc=0 then 4 -> instr 8c040000 then 20100000, instr_valid 1, ld_words 2.
REQ-033 Stall held 3 cycles with pc changing -> instr constant; flush with stall -> instr 00000000, instr_valid 0.
REQ-034 Load 3 bytes then ld_end -> ld_words 0, word 0 unchanged; ld_start mid-word -> pointer 0, next 4 bytes land at word 0.
REQ-035 ADDR_W=2: load 5 words -> ld_ready low after 4th, ld_words 4; pc=32'h00000010 -> instr 00000000, instr_valid 1.
REQ-036 Reset pulse mid-load after 2 bytes -> state RUN, outputs at reset values, previously written words readable unchanged.
REQ-037 IMEM_PARITY_EN defined: force a stored bit flip via backdoor -> parity_err 1 one cycle after fetch; clean word -> 0.
